cla_pipe_addsub: RTL

- Parametrised, pipelined carry-lookahead adder/subtractor.
- Successor to the 4-bit single-cycle CLA adder.
- Splits a WIDTH-bit operation into GROUP-bit lookahead groups, resolving one group per pipeline stage, and adds subtract mode, signed-overflow and zero flags.
- Uses a valid/ready handshake at both ends so it can sit between the register file and ALU result mux in the course datapath.

---
 rtl/cla_pipe_addsub_if.sv | 19 +
 rtl/cla_pipe_addsub.sv | 105 ++++++++++
 2 files changed

// File: rtl/cla_pipe_addsub_if.sv
// cla_pipe_addsub_if: valid/ready operand and result bus for cla_pipe_addsub
//   in_valid/in_ready/a/b/c_in/sub : operand beat, source -> adder
//   out_valid/out_ready/sum/c_out/ovf/zero : result beat, adder -> sink
//   master : source/sink side; slave : adder side
interface cla_pipe_addsub_if #(
   parameter int WIDTH = 16
);
   logic             in_valid, in_ready, c_in, sub;
   logic [WIDTH-1:0] a, b, sum;
   logic             out_valid, out_ready, c_out, ovf, zero;
   modport master (
      output in_valid, a, b, c_in, sub, out_ready,
      input  in_ready, out_valid, sum, c_out, ovf, zero
   );
   modport slave (
      input  in_valid, a, b, c_in, sub, out_ready,
      output in_ready, out_valid, sum, c_out, ovf, zero
   );
endinterface

// File: rtl/cla_pipe_addsub.sv
// cla_pipe_addsub: pipelined CLA adder/subtractor, one GROUP-bit lookahead group resolved per stage
//   clk    : clock, all state on rising edge
//   rst    : synchronous active-high reset, drops every in-flight beat
//   io_bus : slave side of cla_pipe_addsub_if (operand beat in, result beat out, valid/ready both ends)
module cla_pipe_addsub #(
   parameter int WIDTH = 16,
   parameter int GROUP = 4
) (
   input  logic             clk,
   input  logic             rst,
   cla_pipe_addsub_if.slave io_bus
);
   localparam int NG = WIDTH / GROUP;
   if (WIDTH % GROUP != 0) begin : g_bad
      $error("cla_pipe_addsub: WIDTH must be a multiple of GROUP");
   end
   // flat sum-of-products carries: c[i+1] = g[i] | p[i]g[i-1] | ... | p[i..0]c[0], no ripple
   function automatic logic [GROUP:0] f_cla(input logic [GROUP-1:0] p, input logic [GROUP-1:0] g, input logic ci);
      logic [GROUP:0] c;
      logic           t;
      c    = '0;
      c[0] = ci;
      for (int i = 0; i < GROUP; i++) begin
         t = ci;
         for (int m = 0; m <= i; m++) t = t & p[m];
         c[i+1] = t;
         for (int j = 0; j <= i; j++) begin
            t = g[j];
            for (int m = j + 1; m <= i; m++) t = t & p[m];
            c[i+1] = c[i+1] | t;
         end
      end
      return c;
   endfunction
   logic w_en;
   assign w_en            = !io_bus.out_valid || io_bus.out_ready;
   assign io_bus.in_ready = w_en;
   for (genvar k = 0; k < NG; k++) begin : g_stg
      // operand bits not yet consumed by earlier stages
      localparam int RW = WIDTH - k * GROUP;
      logic [RW-1:0]          w_a, w_bb;
      logic                   w_ci, w_vld;
      logic [GROUP-1:0]       w_p, w_g;
      logic [GROUP:0]         w_c;
      logic [(k+1)*GROUP-1:0] w_sum;
      logic                   r_vld;
      logic [(k+1)*GROUP-1:0] r_sum;
      if (k == 0) begin : g_src
         assign w_vld = io_bus.in_valid;
         assign w_a   = io_bus.a;
         assign w_bb  = io_bus.sub ? ~io_bus.b : io_bus.b;
         assign w_ci  = io_bus.c_in ^ io_bus.sub;
         assign w_sum = w_p ^ w_c[GROUP-1:0];
      end else begin : g_src
         assign w_vld = g_stg[k-1].r_vld;
         assign w_a   = g_stg[k-1].g_op.r_a;
         assign w_bb  = g_stg[k-1].g_op.r_bb;
         assign w_ci  = g_stg[k-1].g_op.r_c;
         assign w_sum = {w_p ^ w_c[GROUP-1:0], g_stg[k-1].r_sum};
      end
      // p must be XOR: it doubles as the half-sum for the sum bit
      assign w_p = w_a[GROUP-1:0] ^ w_bb[GROUP-1:0];
      assign w_g = w_a[GROUP-1:0] & w_bb[GROUP-1:0];
      assign w_c = f_cla(w_p, w_g, w_ci);
      always_ff @(posedge clk)
         if (rst) begin
            r_vld <= 1'b0;
            r_sum <= '0;
         end else if (w_en) begin
            r_vld <= w_vld;
            r_sum <= w_sum;
         end
      if (k < NG - 1) begin : g_op
         logic [RW-GROUP-1:0] r_a, r_bb;
         logic                r_c;
         always_ff @(posedge clk)
            if (rst) begin
               r_a  <= '0;
               r_bb <= '0;
               r_c  <= 1'b0;
            end else if (w_en) begin
               r_a  <= w_a[RW-1:GROUP];
               r_bb <= w_bb[RW-1:GROUP];
               r_c  <= w_c[GROUP];
            end
      end
   end
   logic r_cout, r_ovf, r_zero;
   // overflow = carry into MSB xor carry out of MSB, both from the last group
   always_ff @(posedge clk)
      if (rst) begin
         r_cout <= 1'b0;
         r_ovf  <= 1'b0;
         r_zero <= 1'b0;
      end else if (w_en) begin
         r_cout <= g_stg[NG-1].w_c[GROUP];
         r_ovf  <= g_stg[NG-1].w_c[GROUP] ^ g_stg[NG-1].w_c[GROUP-1];
         r_zero <= ~|g_stg[NG-1].w_sum;
      end
   assign io_bus.out_valid = g_stg[NG-1].r_vld;
   assign io_bus.sum       = g_stg[NG-1].r_sum;
   assign io_bus.c_out     = r_cout;
   assign io_bus.ovf       = r_ovf;
   assign io_bus.zero      = r_zero;
endmodule
